// File: rtl/dunc_pkg.sv
// Shared opcode constants and state encoding for the DUNC accumulator core.
package dunc_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_BAN = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_BZ  = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_e;

endpackage

// File: rtl/dunc_alu.sv
// Accumulator update for the memory-operand instructions; any other opcode
// leaves the accumulator untouched (STA relies on this pass-through).
module dunc_alu
    import dunc_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] ac,
    input  logic [DW-1:0] operand,
    output logic [DW-1:0] ac_next
);

    always_comb begin
        ac_next = ac;
        case (op)
            OP_LDA:  ac_next = operand;
            OP_ADD:  ac_next = ac + operand;
            OP_SUB:  ac_next = ac - operand;
            OP_AND:  ac_next = ac & operand;
            default: ac_next = ac;
        endcase
    end

endmodule

// File: rtl/dunc_core.sv
// DUNC accumulator processor: handshake-driven FETCH/DECODE/EXEC/HALT machine
// with PC, IR and AC registers; works with any number of memory wait states.
module dunc_core
    import dunc_pkg::*;
#(
    parameter int              DW       = 16,
    parameter logic [DW-5:0]   RESET_PC = '0
) (
    input  logic          CLK,
    input  logic          RESET,
    output logic          MEM_REQ,
    output logic          MEM_WE,
    output logic [DW-5:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    input  logic          MEM_RDY,
    output logic [DW-5:0] PC_OUT,
    output logic [DW-1:0] AC_OUT,
    output logic [3:0]    IR_OUT,
    output logic          AZ,
    output logic          AN,
    output logic          HALTED
);

    localparam int AW = DW - 4;
    localparam logic [AW-1:0] PC_STEP = {{(AW-1){1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] ac_q, ac_d;
    logic [DW-1:0] alu_ac;
    logic [3:0]    op;
    logic [AW-1:0] opnd;

    assign op   = ir_q[DW-1:DW-4];
    assign opnd = ir_q[AW-1:0];

    dunc_alu #(.DW(DW)) u_alu (
        .op      (op),
        .ac      (ac_q),
        .operand (MEM_RDATA),
        .ac_next (alu_ac)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ac_d    = ac_q;

        case (state_q)
            S_FETCH: begin
                if (MEM_RDY) begin
                    ir_d    = MEM_RDATA;
                    pc_d    = pc_q + PC_STEP;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                case (op)
                    OP_JMP: pc_d = opnd;
                    OP_BAN: if (ac_q[DW-1]) pc_d = opnd;
                    OP_BZ:  if (ac_q == '0) pc_d = opnd;
                    OP_HLT: state_d = S_HALT;
                    OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND: state_d = S_EXEC;
                    default: state_d = S_FETCH;
                endcase
            end
            S_EXEC: begin
                if (MEM_RDY) begin
                    ac_d    = alu_ac;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // The request is gated by RESET so it drops the instant reset asserts.
    always_comb begin
        MEM_REQ   = 1'b0;
        MEM_WE    = 1'b0;
        MEM_ADDR  = (state_q == S_EXEC) ? opnd : pc_q;
        MEM_WDATA = ac_q;
        if (RESET) begin
            MEM_REQ = (state_q == S_FETCH) || (state_q == S_EXEC);
            MEM_WE  = (state_q == S_EXEC) && (op == OP_STA);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ac_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ac_q    <= ac_d;
        end
    end

    assign PC_OUT = pc_q;
    assign AC_OUT = ac_q;
    assign IR_OUT = op;
    assign AZ     = (ac_q == '0);
    assign AN     = ac_q[DW-1];
    assign HALTED = (state_q == S_HALT);

endmodule
